// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/halt control for the five-stage pipeline.
// Ports: CLK, nRST, ihit, dhit, rs1_ID, rs2_ID, wsel_EX, MemRead_EX,
//   RegWr_EX, MemRead_MEM, MemWr_MEM, branch_taken_EX, j_en_EX,
//   is_halt_EX -> pc_en, if_id_en, flush_IF_ID, pipeline_ctrl,
//   flush_ID_EX, ex_mem_en, halt.
// Optional macro HAZARD_UNIT_PERF_EN adds stall_cycles/flush_events.
module hazard_unit #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic [4:0]  wsel_EX,
  input  logic        MemRead_EX,
  input  logic        RegWr_EX,
  input  logic        MemRead_MEM,
  input  logic        MemWr_MEM,
  input  logic        branch_taken_EX,
  input  logic        j_en_EX,
  input  logic        is_halt_EX,
`ifdef HAZARD_UNIT_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
`endif
  output logic        pc_en,
  output logic        if_id_en,
  output logic        flush_IF_ID,
  output logic        pipeline_ctrl,
  output logic        flush_ID_EX,
  output logic        ex_mem_en,
  output logic        halt
);

  typedef enum logic [1:0] {
    RUN, MEM_WAIT, DRAIN, HALTED
  } state_t;

  state_t     r_state, w_next;
  logic [1:0] r_cnt, w_cnt_next;

  logic w_freeze, w_redir, w_lu, w_redir_fire;
  logic w_pc, w_ifid, w_fifid, w_idex, w_fidex, w_exmem, w_halt;

  assign w_freeze = (MemRead_MEM | MemWr_MEM) & ~dhit;
  assign w_redir  = branch_taken_EX | j_en_EX;
  assign w_lu     = MemRead_EX & RegWr_EX & (wsel_EX != 5'd0)
                  & ((wsel_EX == rs1_ID) | (wsel_EX == rs2_ID));

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_pc         = 1'b0;
    w_ifid       = 1'b0;
    w_fifid      = 1'b0;
    w_idex       = 1'b0;
    w_fidex      = 1'b0;
    w_exmem      = 1'b0;
    w_halt       = 1'b0;
    w_redir_fire = 1'b0;
    priority case (1'b1)
      (r_state == HALTED): begin
        w_halt = 1'b1;
      end
      w_freeze: begin
        // DRAIN holds its count; other states park in MEM_WAIT
        if (r_state != DRAIN) w_next = MEM_WAIT;
      end
      (r_state == DRAIN): begin
        w_ifid     = 1'b1;
        w_fifid    = 1'b1;
        w_idex     = 1'b1;
        w_fidex    = 1'b1;
        w_exmem    = 1'b1;
        w_cnt_next = r_cnt + 2'd1;
        if (r_cnt == 2'(DRAIN_CYCLES - 1)) w_next = HALTED;
      end
      is_halt_EX: begin
        w_ifid     = 1'b1;
        w_fifid    = 1'b1;
        w_idex     = 1'b1;
        w_fidex    = 1'b1;
        w_exmem    = 1'b1;
        w_next     = DRAIN;
        w_cnt_next = 2'd0;
      end
      w_redir: begin
        w_next       = RUN;
        w_pc         = 1'b1;
        w_ifid       = 1'b1;
        w_fifid      = 1'b1;
        w_idex       = 1'b1;
        w_fidex      = 1'b1;
        w_exmem      = 1'b1;
        w_redir_fire = 1'b1;
      end
      w_lu: begin
        w_next  = RUN;
        w_idex  = 1'b1;
        w_fidex = 1'b1;
        w_exmem = 1'b1;
      end
      !ihit: begin
        w_next  = RUN;
        w_ifid  = 1'b1;
        w_fifid = 1'b1;
        w_idex  = 1'b1;
        w_exmem = 1'b1;
      end
      default: begin
        w_next  = RUN;
        w_pc    = 1'b1;
        w_ifid  = 1'b1;
        w_idex  = 1'b1;
        w_exmem = 1'b1;
      end
    endcase
  end

  // outputs are forced low while reset is held
  assign pc_en         = nRST & w_pc;
  assign if_id_en      = nRST & w_ifid;
  assign flush_IF_ID   = nRST & w_fifid;
  assign pipeline_ctrl = nRST & w_idex;
  assign flush_ID_EX   = nRST & w_fidex;
  assign ex_mem_en     = nRST & w_exmem;
  assign halt          = nRST & w_halt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

`ifdef HAZARD_UNIT_PERF_EN
  logic [31:0] r_stall, r_flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall <= 32'd0;
      r_flush <= 32'd0;
    end else begin
      if (!pc_en && !halt && r_stall != 32'hFFFF_FFFF)
        r_stall <= r_stall + 32'd1;
      if (w_redir_fire && r_flush != 32'hFFFF_FFFF)
        r_flush <= r_flush + 32'd1;
    end
  end

  assign stall_cycles = r_stall;
  assign flush_events = r_flush;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: randomized and directed checks of hazard_unit
// against a rule-level reference model.
module tb_hazard_unit;

  localparam int DC = 2;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit;
  logic [4:0] rs1_ID, rs2_ID, wsel_EX;
  logic       MemRead_EX, RegWr_EX, MemRead_MEM, MemWr_MEM;
  logic       branch_taken_EX, j_en_EX, is_halt_EX;
  logic       pc_en, if_id_en, flush_IF_ID, pipeline_ctrl;
  logic       flush_ID_EX, ex_mem_en, halt;
`ifdef HAZARD_UNIT_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  hazard_unit #(.DRAIN_CYCLES(DC)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .wsel_EX(wsel_EX),
    .MemRead_EX(MemRead_EX), .RegWr_EX(RegWr_EX),
    .MemRead_MEM(MemRead_MEM), .MemWr_MEM(MemWr_MEM),
    .branch_taken_EX(branch_taken_EX), .j_en_EX(j_en_EX),
    .is_halt_EX(is_halt_EX),
`ifdef HAZARD_UNIT_PERF_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .pc_en(pc_en), .if_id_en(if_id_en),
    .flush_IF_ID(flush_IF_ID), .pipeline_ctrl(pipeline_ctrl),
    .flush_ID_EX(flush_ID_EX), .ex_mem_en(ex_mem_en),
    .halt(halt)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // model: halted flag plus remaining active drain cycles
  bit m_halted;
  int m_drain;
  int m_stalls, m_flushes;
  bit last_halt;

  // packed {pc_en,if_id_en,flush_IF_ID,pipeline_ctrl,flush_ID_EX,ex_mem_en,halt}
  function automatic logic [6:0] model_out();
    bit frz, lu;
    frz = (MemRead_MEM || MemWr_MEM) && !dhit;
    lu  = MemRead_EX && RegWr_EX && wsel_EX != 0
          && (wsel_EX == rs1_ID || wsel_EX == rs2_ID);
    if (!nRST) return 7'b0;
    if (m_halted) return 7'b0000001;
    if (frz) return 7'b0;
    if (m_drain > 0 || is_halt_EX) return 7'b0111110;
    if (branch_taken_EX || j_en_EX) return 7'b1111110;
    if (lu) return 7'b0001110;
    if (!ihit) return 7'b0111010;
    return 7'b1101010;
  endfunction

  function automatic logic [6:0] dut_out();
    return {pc_en, if_id_en, flush_IF_ID, pipeline_ctrl,
            flush_ID_EX, ex_mem_en, halt};
  endfunction

  task automatic model_clock();
    bit frz;
    logic [6:0] e;
    e   = model_out();
    frz = (MemRead_MEM || MemWr_MEM) && !dhit;
    if (!e[6] && !e[0]) m_stalls++;
    if (!m_halted && !frz && m_drain == 0 && !is_halt_EX
        && (branch_taken_EX || j_en_EX)) m_flushes++;
    if (m_halted || frz) return;
    if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) m_halted = 1;
    end else if (is_halt_EX) begin
      m_drain = DC;
    end
  endtask

  task automatic step(input string tag);
    @(negedge CLK);
    chk(tag, {25'd0, dut_out()}, {25'd0, model_out()});
    last_halt = halt;
    @(posedge CLK);
    model_clock();
    #1;
  endtask

  task automatic quiet();
    ihit = 1; dhit = 1;
    rs1_ID = 0; rs2_ID = 0; wsel_EX = 0;
    MemRead_EX = 0; RegWr_EX = 0;
    MemRead_MEM = 0; MemWr_MEM = 0;
    branch_taken_EX = 0; j_en_EX = 0; is_halt_EX = 0;
  endtask

  task automatic rand_in(input bit allow_halt);
    ihit = ($urandom_range(0, 5) != 0);
    dhit = $urandom_range(0, 1);
    rs1_ID = 5'($urandom_range(0, 7));
    rs2_ID = 5'($urandom_range(0, 7));
    wsel_EX = 5'($urandom_range(0, 7));
    MemRead_EX = $urandom_range(0, 1);
    RegWr_EX = $urandom_range(0, 1);
    MemRead_MEM = ($urandom_range(0, 3) == 0);
    MemWr_MEM = ($urandom_range(0, 7) == 0);
    branch_taken_EX = ($urandom_range(0, 5) == 0);
    j_en_EX = ($urandom_range(0, 9) == 0);
    is_halt_EX = allow_halt && ($urandom_range(0, 39) == 0);
  endtask

  task automatic do_reset();
    nRST = 0;
    #2;
    chk("rst_outs", {25'd0, dut_out()}, 32'd0);
    m_halted = 0; m_drain = 0;
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int k;
    quiet();
    nRST = 0;
    m_halted = 0; m_drain = 0;
    m_stalls = 0; m_flushes = 0;
    #12;
    chk("reset_state", {25'd0, dut_out()}, 32'd0);
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK);
    #1;
    step("idle");

    // load-use on rs2, then clears when load leaves EX
    MemRead_EX = 1; RegWr_EX = 1; wsel_EX = 5; rs2_ID = 5;
    step("lu");
    chk("lu_pc", {31'd0, last_halt}, 32'd0);
    quiet();
    step("lu_after");
    MemRead_EX = 1; RegWr_EX = 1; wsel_EX = 0; rs1_ID = 0;
    step("lu_x0");
    quiet();

    // redirect with a matching load-use
    branch_taken_EX = 1;
    MemRead_EX = 1; RegWr_EX = 1; wsel_EX = 3; rs1_ID = 3;
    step("redir_lu");
    quiet();
    step("redir_after");

    // three-cycle freeze during redirect
    branch_taken_EX = 1; MemRead_MEM = 1; dhit = 0;
    for (int i = 0; i < 3; i++) step("freeze");
    dhit = 1;
    step("freeze_rel");
    quiet();

    // halt latency without freeze
    is_halt_EX = 1;
    step("halt_acc");
    is_halt_EX = 0;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      step("drain");
      if (last_halt) begin k = i; break; end
    end
    chk("halt_lat", k, DC + 1);
    for (int i = 0; i < 5; i++) begin rand_in(1); step("halted"); end
    chk("halt_sticky", {31'd0, last_halt}, 32'd1);
    quiet();
    do_reset();

    // halt latency with a 2-cycle freeze inside DRAIN
    is_halt_EX = 1;
    step("halt_acc2");
    is_halt_EX = 0;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      MemRead_MEM = (i == 2 || i == 3);
      dhit = !(i == 2 || i == 3);
      step("drain_frz");
      if (last_halt) begin k = i; break; end
    end
    chk("halt_lat_frz", k, DC + 3);
    quiet();
    do_reset();

    // reset mid-drain
    is_halt_EX = 1;
    step("halt_acc3");
    is_halt_EX = 0;
    step("drain_mid");
    do_reset();
    step("post_rst");
    chk("post_rst_halt", {31'd0, last_halt}, 32'd0);

    // randomized run with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rand_in(1);
      step("rand");
      if (m_halted && $urandom_range(0, 3) == 0) begin
        quiet();
        do_reset();
      end
    end

`ifdef HAZARD_UNIT_PERF_EN
    quiet();
    do_reset();
    m_stalls = 0; m_flushes = 0;
    for (int i = 0; i < 4; i++) begin
      MemRead_EX = 1; RegWr_EX = 1; wsel_EX = 7; rs1_ID = 7;
      step("perf_lu");
      quiet();
      step("perf_gap");
    end
    for (int i = 0; i < 2; i++) begin
      j_en_EX = 1;
      step("perf_rd");
      quiet();
      step("perf_gap");
    end
    chk("stall_cycles", stall_cycles, 4);
    chk("flush_events", flush_events, 2);
    chk("stall_model", stall_cycles, m_stalls);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
